// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the adder arbiter: FSM state encoding,
// default lane geometry, and the index wrap helper used by the round-robin picker.
package adder_arbiter_pkg;

    localparam int LANES_P = 4;
    localparam int WIDTH_P = 32;

    typedef logic [LANES_P-1:0][WIDTH_P-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Wrap a requester index that may have run one step past the last requester.
    function automatic int wrap_index(input int idx, input int n);
        if (idx >= n) begin
            return idx - n;
        end else begin
            return idx;
        end
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector. Searches upward from last_grant+1 with
// wrap-around and returns the first pending requester as one-hot and index.
module rr_picker
    import adder_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    // Priority scan starting just after the previous winner; first hit wins.
    always_comb begin
        int cand;
        cand      = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = wrap_index(int'(last_grant) + i, NREQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IW'(cand);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-lane adder among NREQ
// requesters. One addition is in flight at a time: accept operands, pulse the
// adder start, wait for ready or a watchdog timeout, then hand the lane sums
// back to the granted requester.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LANES   = LANES_P,
    parameter int WIDTH   = WIDTH_P,
    parameter int TIMEOUT = 64
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NREQ-1:0]                          req_valid,
    output logic [NREQ-1:0]                          req_ready,
    input  logic [NREQ-1:0][LANES-1:0][WIDTH-1:0]    req_a,
    input  logic [NREQ-1:0][LANES-1:0][WIDTH-1:0]    req_b,
    input  logic [NREQ-1:0]                          req_ci,
    output logic [NREQ-1:0]                          rsp_valid,
    input  logic [NREQ-1:0]                          rsp_ready,
    output logic [LANES-1:0][WIDTH-1:0]              rsp_sum,
    output logic                                     rsp_err,
    output logic                                     add_start,
    output logic [LANES-1:0][WIDTH-1:0]              add_a,
    output logic [LANES-1:0][WIDTH-1:0]              add_b,
    output logic                                     add_ci,
    input  logic                                     add_ready,
    input  logic [LANES-1:0][WIDTH-1:0]              add_sum,
    output logic                                     busy,
    output logic [$clog2(NREQ)-1:0]                  grant_id
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t                        state_r;
    state_t                        state_s;
    logic [IW-1:0]                 last_grant_r;
    logic [IW-1:0]                 grant_id_r;
    logic [TW-1:0]                 timer_r;
    logic                          add_start_r;
    logic [LANES-1:0][WIDTH-1:0]   add_a_r;
    logic [LANES-1:0][WIDTH-1:0]   add_b_r;
    logic                          add_ci_r;
    logic [LANES-1:0][WIDTH-1:0]   rsp_sum_r;
    logic                          rsp_err_r;
    logic [NREQ-1:0]               rsp_valid_r;
    logic                          busy_r;

    logic [NREQ-1:0]               pick_grant_s;
    logic [IW-1:0]                 pick_idx_s;
    logic                          pick_any_s;
    logic                          accept_s;
    logic                          timeout_s;
    logic [NREQ-1:0]               grant_oh_s;
    logic [NREQ-1:0]               req_ready_s;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (pick_grant_s),
        .grant_idx  (pick_idx_s),
        .any        (pick_any_s)
    );

    assign accept_s   = (state_r == IDLE) && pick_any_s;
    assign timeout_s  = (timer_r == TW'(TIMEOUT - 1));
    assign grant_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_r;

    // Next-state logic: IDLE -> ISSUE on a grant, ISSUE -> WAIT always,
    // WAIT -> RESP on ready or timeout, RESP -> IDLE on the granted handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (add_ready || timeout_s) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready[grant_id_r]) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Accept strobe is combinational; gated by reset so it reads 0 while held in reset.
    always_comb begin
        req_ready_s = '0;
        if (reset && (state_r == IDLE)) begin
            req_ready_s = pick_grant_s;
        end else begin
            req_ready_s = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant bookkeeping and operand capture; operands hold until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r <= IW'(NREQ - 1);
            grant_id_r   <= '0;
            add_a_r      <= '0;
            add_b_r      <= '0;
            add_ci_r     <= 1'b0;
            add_start_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            add_start_r <= accept_s;
            busy_r      <= (state_s != IDLE);
            if (accept_s) begin
                grant_id_r <= pick_idx_s;
                add_a_r    <= req_a[pick_idx_s];
                add_b_r    <= req_b[pick_idx_s];
                add_ci_r   <= req_ci[pick_idx_s];
            end
            if ((state_r == RESP) && rsp_ready[grant_id_r]) begin
                last_grant_r <= grant_id_r;
            end
        end
    end

    // Watchdog: cleared during ISSUE, counts every WAIT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r <= '0;
        end else begin
            case (state_r)
                ISSUE:   timer_r <= '0;
                WAIT:    timer_r <= timer_r + TW'(1);
                default: timer_r <= timer_r;
            endcase
        end
    end

    // Response capture: adder ready takes priority over a coincident timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_sum_r   <= '0;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= '0;
        end else begin
            case (state_r)
                WAIT: begin
                    if (add_ready) begin
                        rsp_sum_r   <= add_sum;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= grant_oh_s;
                    end else if (timeout_s) begin
                        rsp_sum_r   <= '0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= grant_oh_s;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_id_r]) begin
                        rsp_valid_r <= '0;
                    end
                end
                default: begin
                    rsp_valid_r <= '0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_sum   = rsp_sum_r;
    assign rsp_err   = rsp_err_r;
    assign add_start = add_start_r;
    assign add_a     = add_a_r;
    assign add_b     = add_b_r;
    assign add_ci    = add_ci_r;
    assign busy      = busy_r;
    assign grant_id  = grant_id_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset values, round-robin order, latency,
// timeout, ready/timeout tie, response stall, early ready and mid-flight reset.
module tb_adder_arbiter;
    import adder_arbiter_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic                                   clk;
    logic                                   reset;
    logic [NREQ-1:0]                        req_valid;
    logic [NREQ-1:0]                        req_ready;
    logic [NREQ-1:0][LANES_P-1:0][WIDTH_P-1:0] req_a;
    logic [NREQ-1:0][LANES_P-1:0][WIDTH_P-1:0] req_b;
    logic [NREQ-1:0]                        req_ci;
    logic [NREQ-1:0]                        rsp_valid;
    logic [NREQ-1:0]                        rsp_ready;
    lane_vec_t                              rsp_sum;
    logic                                   rsp_err;
    logic                                   add_start;
    lane_vec_t                              add_a;
    lane_vec_t                              add_b;
    logic                                   add_ci;
    logic                                   add_ready;
    lane_vec_t                              add_sum;
    logic                                   busy;
    logic [1:0]                             grant_id;

    int n_tests = 0;
    int n_fail  = 0;

    adder_arbiter #(
        .NREQ    (NREQ),
        .LANES   (LANES_P),
        .WIDTH   (WIDTH_P),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_ready (add_ready),
        .add_sum   (add_sum),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int g);
        return 4'b0001 << g;
    endfunction

    // Reference adder: independent 32-bit lanes, carry-in into lane 0 only.
    function automatic logic [127:0] model_sum(input logic [127:0] a, input logic [127:0] b, input logic ci);
        logic [127:0] s;
        logic [31:0]  c;
        s = '0;
        for (int l = 0; l < 4; l++) begin
            c = (l == 0) ? {31'd0, ci} : 32'd0;
            s[l*32 +: 32] = a[l*32 +: 32] + b[l*32 +: 32] + c;
        end
        return s;
    endfunction

    // One transaction from the IDLE accept cycle through the response handshake.
    // k < 0 means the adder never answers. Entered and left mid-cycle in IDLE.
    task automatic run_op(input int g, input int k, input int stall,
                          input logic [127:0] ea, input logic [127:0] eb, input logic eci,
                          input logic [127:0] sum_in, input logic [127:0] exp_sum,
                          input logic exp_err, input bit early);
        if (early) begin
            add_ready = 1'b1;
            add_sum   = {4{32'hDEADBEEF}};
        end
        #1;
        chk("req_ready_accept", 128'(req_ready), 128'(oh(g)));
        chk("busy_idle", 128'(busy), 128'd0);
        @(negedge clk);
        chk("add_start_issue", 128'(add_start), 128'd1);
        chk("grant_id", 128'(grant_id), 128'(g));
        chk("add_a", add_a, ea);
        chk("add_b", add_b, eb);
        chk("add_ci", 128'(add_ci), 128'(eci));
        chk("req_ready_issue", 128'(req_ready), 128'd0);
        chk("busy_issue", 128'(busy), 128'd1);
        @(negedge clk);
        add_ready = 1'b0;
        add_sum   = '0;
        chk("add_start_wait", 128'(add_start), 128'd0);
        chk("rsp_valid_wait0", 128'(rsp_valid), 128'd0);
        if (k >= 0) begin
            repeat (k) @(negedge clk);
            chk("rsp_before_ready", 128'(rsp_valid), 128'd0);
            add_ready = 1'b1;
            add_sum   = sum_in;
            @(negedge clk);
            add_ready = 1'b0;
            add_sum   = '0;
        end else begin
            repeat (TIMEOUT - 1) @(negedge clk);
            chk("no_early_timeout", 128'(rsp_valid), 128'd0);
            @(negedge clk);
        end
        chk("rsp_valid", 128'(rsp_valid), 128'(oh(g)));
        chk("rsp_sum", rsp_sum, exp_sum);
        chk("rsp_err", 128'(rsp_err), 128'(exp_err));
        for (int i = 0; i < stall; i++) begin
            rsp_ready = ~oh(g);
            @(negedge clk);
            chk("stall_rsp_valid", 128'(rsp_valid), 128'(oh(g)));
            chk("stall_rsp_sum", rsp_sum, exp_sum);
            chk("stall_req_ready", 128'(req_ready), 128'd0);
        end
        rsp_ready = oh(g);
        @(negedge clk);
        rsp_ready = '0;
        chk("rsp_valid_done", 128'(rsp_valid), 128'd0);
        chk("busy_done", 128'(busy), 128'd0);
    endtask

    initial begin
        logic [127:0] s;
        reset     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = '0;
        add_ready = 1'b0;
        add_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i]  = {4{32'h01010101 * 32'(i + 1)}};
            req_b[i]  = {4{32'h10000000 + 32'(i)}};
            req_ci[i] = 1'(i & 1);
        end

        // Reset values, with requests pending while held in reset.
        @(negedge clk);
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_add_start", 128'(add_start), 128'd0);
        chk("rst_add_a", add_a, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_grant_id", 128'(grant_id), 128'd0);
        reset = 1'b1;

        // All requesters valid: grants rotate 0,1,2,3,0.
        for (int n = 0; n < 5; n++) begin
            s = model_sum(req_a[n % 4], req_b[n % 4], req_ci[n % 4]);
            run_op(n % 4, 0, 0, req_a[n % 4], req_b[n % 4], req_ci[n % 4], s, s, 1'b0, 1'b0);
        end

        // Single request on requester 0, adder answers two cycles into WAIT.
        req_valid = 4'h1;
        req_a[0]  = 128'h00000001_00600041_02005001_04002001;
        req_b[0]  = 128'h00011001_002104C0_20508001_06000031;
        req_ci[0] = 1'b0;
        run_op(0, 2, 0, req_a[0], req_b[0], 1'b0,
               128'h00011002_00810501_2250D002_0A002032,
               128'h00011002_00810501_2250D002_0A002032, 1'b0, 1'b0);

        // Adder never answers: error response with zero sum.
        req_valid = 4'h8;
        run_op(3, -1, 0, req_a[3], req_b[3], req_ci[3], 128'd0, 128'd0, 1'b1, 1'b0);

        // Normal operation resumes after a timeout.
        req_valid = 4'h2;
        s = model_sum(req_a[1], req_b[1], req_ci[1]);
        run_op(1, 1, 0, req_a[1], req_b[1], req_ci[1], s, s, 1'b0, 1'b0);

        // Ready arrives in the same cycle the watchdog expires: ready wins.
        req_valid = 4'h4;
        s = model_sum(req_a[2], req_b[2], req_ci[2]);
        run_op(2, TIMEOUT - 1, 0, req_a[2], req_b[2], req_ci[2], s, s, 1'b0, 1'b0);

        // Response held off for 10 cycles; other requesters' rsp_ready ignored.
        req_valid = 4'hF;
        s = model_sum(req_a[3], req_b[3], req_ci[3]);
        run_op(3, 0, 10, req_a[3], req_b[3], req_ci[3], s, s, 1'b0, 1'b0);

        // Early ready in IDLE and ISSUE ignored; lanes wrap to zero.
        req_valid = 4'h1;
        req_a[0]  = {4{32'hFFFFFFFF}};
        req_b[0]  = {4{32'h00000001}};
        req_ci[0] = 1'b0;
        s = model_sum(req_a[0], req_b[0], 1'b0);
        run_op(0, 0, 0, req_a[0], req_b[0], 1'b0, s, 128'd0, 1'b0, 1'b1);

        // Reset pulsed during WAIT clears everything at once.
        req_valid = 4'h2;
        #1;
        chk("pre_rst_accept", 128'(req_ready), 128'h2);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_grant_id", 128'(grant_id), 128'd0);
        chk("mid_rst_add_a", add_a, 128'd0);
        chk("mid_rst_add_b", add_b, 128'd0);
        chk("mid_rst_add_ci", 128'(add_ci), 128'd0);
        chk("mid_rst_req_ready", 128'(req_ready), 128'd0);
        chk("mid_rst_rsp_valid", 128'(rsp_valid), 128'd0);
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 4'hF;
        s = model_sum(req_a[0], req_b[0], req_ci[0]);
        run_op(0, 0, 0, req_a[0], req_b[0], req_ci[0], s, s, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
